// File: rtl/hella_cache_slave_mem.sv
// Memory-backed hella-cache responder: in-order tagged responses RSP_LATENCY cycles after accept, nack on unknown cmd.
// req_ready is low in reset and the cycle after; HELLA_CACHE_SLAVE_MEM_BACKPRESSURE_EN gates it with an LFSR instead.
module hella_cache_slave_mem #(
  parameter int          NUM_ADDR_BITS = 32,
  parameter int          NUM_DATA_BITS = 32,
  parameter int          NUM_TAG_BITS  = 7,
  parameter int          MEM_WORDS     = 1024,
  parameter int          RSP_LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_ADDR_BITS-1:0]   req_addr,
  output logic                       req_ready,
  input  logic                       req_valid,
  input  logic [NUM_TAG_BITS-1:0]    req_tag,
  input  logic [4:0]                 req_cmd,
  input  logic [2:0]                 req_typ,
  input  logic [NUM_DATA_BITS-1:0]   req_data,
  input  logic [NUM_DATA_BITS/8-1:0] req_data_mask,
  input  logic                       req_kill,
  output logic                       rsp_valid,
  output logic                       rsp_nack,
  output logic [NUM_TAG_BITS-1:0]    rsp_tag,
  output logic [2:0]                 rsp_typ,
  output logic [NUM_DATA_BITS-1:0]   rsp_data
);

  localparam int MASK_BITS  = NUM_DATA_BITS / 8;
  localparam int OFF_BITS   = $clog2(MASK_BITS);
  localparam int IDX_BITS   = $clog2(MEM_WORDS);
  localparam int PIPE_DEPTH = RSP_LATENCY - 1;
  localparam logic [4:0] CMD_LOAD  = 5'd0;
  localparam logic [4:0] CMD_STORE = 5'd1;

  typedef struct packed {
    logic                     vld;
    logic                     nack;
    logic [NUM_TAG_BITS-1:0]  tag;
    logic [2:0]               typ;
    logic [NUM_DATA_BITS-1:0] data;
  } rsp_t;

  logic                     accept;
  logic                     s1_vld_q, s1_vld_d;
  logic [IDX_BITS-1:0]      s1_idx_q, s1_idx_d;
  logic [NUM_TAG_BITS-1:0]  s1_tag_q, s1_tag_d;
  logic [4:0]               s1_cmd_q, s1_cmd_d;
  logic [2:0]               s1_typ_q, s1_typ_d;
  logic [MASK_BITS-1:0]     s1_mask_q, s1_mask_d;
  logic                     s1_live, is_load, is_store, mem_we;
  logic [NUM_DATA_BITS-1:0] rd_word, wr_word;
  logic [NUM_DATA_BITS-1:0] mem_q [MEM_WORDS];
  rsp_t                     pipe_q [PIPE_DEPTH];
  rsp_t                     pipe_d [PIPE_DEPTH];
  logic                     unused_addr;

  assign unused_addr = ^req_addr;

`ifdef HELLA_CACHE_SLAVE_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (reset) lfsr_d = LFSR_SEED;
  end

  always_ff @(posedge clock) lfsr_q <= lfsr_d;

  assign req_ready = ~reset & lfsr_q[0];
`else
  localparam logic [15:0] unused_seed = LFSR_SEED;
  logic reset_q, reset_d;

  always_comb reset_d = reset;
  always_ff @(posedge clock) reset_q <= reset_d;

  assign req_ready = ~reset & ~reset_q;
`endif

  always_comb begin
    accept    = req_valid & req_ready;
    s1_vld_d  = accept & ~reset;
    s1_idx_d  = req_addr[OFF_BITS +: IDX_BITS];
    s1_tag_d  = req_tag;
    s1_cmd_d  = req_cmd;
    s1_typ_d  = req_typ;
    s1_mask_d = req_data_mask;
  end

  always_ff @(posedge clock) begin
    s1_vld_q  <= s1_vld_d;
    s1_idx_q  <= s1_idx_d;
    s1_tag_q  <= s1_tag_d;
    s1_cmd_q  <= s1_cmd_d;
    s1_typ_q  <= s1_typ_d;
    s1_mask_q <= s1_mask_d;
  end

  // Kill and store data both belong to the op sitting in S1 this cycle.
  always_comb begin
    s1_live  = s1_vld_q & ~req_kill & ~reset;
    is_load  = (s1_cmd_q == CMD_LOAD);
    is_store = (s1_cmd_q == CMD_STORE);
    mem_we   = s1_live & is_store;
    rd_word  = mem_q[s1_idx_q];
    for (int b = 0; b < MASK_BITS; b++) begin
      wr_word[b*8 +: 8] = s1_mask_q[b] ? req_data[b*8 +: 8] : rd_word[b*8 +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[s1_idx_q] <= wr_word;
  end

  always_comb begin
    pipe_d[0] = '0;
    if (s1_live) begin
      pipe_d[0].vld  = 1'b1;
      pipe_d[0].nack = ~(is_load | is_store);
      pipe_d[0].tag  = s1_tag_q;
      pipe_d[0].typ  = s1_typ_q;
      pipe_d[0].data = is_load ? rd_word : '0;
    end
    for (int i = 1; i < PIPE_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_d[i] = '0;
    end
  end

  always_ff @(posedge clock) pipe_q <= pipe_d;

  always_comb begin
    rsp_valid = pipe_q[PIPE_DEPTH-1].vld & ~pipe_q[PIPE_DEPTH-1].nack;
    rsp_nack  = pipe_q[PIPE_DEPTH-1].vld &  pipe_q[PIPE_DEPTH-1].nack;
    rsp_tag   = pipe_q[PIPE_DEPTH-1].tag;
    rsp_typ   = pipe_q[PIPE_DEPTH-1].typ;
    rsp_data  = pipe_q[PIPE_DEPTH-1].data;
  end

endmodule

// File: tb/tb_hella_cache_slave_mem.sv
// Randomised bench for hella_cache_slave_mem against an in-order memory/response reference model.
// Covers reset, store/load hazard, byte masks, nack, kill, address wrap, mid-pipeline reset, backpressure.
module tb_hella_cache_slave_mem;
  localparam int AW = 32, DW = 32, TW = 7, WORDS = 1024, L = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          req_valid = 1'b0;
  logic [TW-1:0] req_tag = '0;
  logic [4:0]    req_cmd = '0;
  logic [2:0]    req_typ = '0;
  logic [DW-1:0] req_data = '0;
  logic [3:0]    req_data_mask = '0;
  logic          req_kill = 1'b0;
  logic          rsp_valid, rsp_nack;
  logic [TW-1:0] rsp_tag;
  logic [2:0]    rsp_typ;
  logic [DW-1:0] rsp_data;

  hella_cache_slave_mem #(
    .NUM_ADDR_BITS(AW), .NUM_DATA_BITS(DW), .NUM_TAG_BITS(TW),
    .MEM_WORDS(WORDS), .RSP_LATENCY(L), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .req_addr(req_addr), .req_ready(req_ready),
    .req_valid(req_valid), .req_tag(req_tag), .req_cmd(req_cmd), .req_typ(req_typ),
    .req_data(req_data), .req_data_mask(req_data_mask), .req_kill(req_kill),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_tag(rsp_tag), .rsp_typ(rsp_typ),
    .rsp_data(rsp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]    cmd;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic [2:0]    typ;
    logic [DW-1:0] data;
    logic [3:0]    mask;
    logic          kill;
  } req_t;

  typedef struct {
    int          due;
    logic [63:0] rsp;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] mm [WORDS];
  bit [31:0] mm_save [WORDS];
  int        n_checks = 0, n_errs = 0, cyc = 0, low_seen = 0;
  logic [31:0] pend_data = '0;
  logic        pend_kill = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_rsp(input logic v, input logic n, input logic [TW-1:0] tag,
                                           input logic [2:0] typ, input logic [DW-1:0] d);
    return {20'b0, v, n, tag, typ, d};
  endfunction

  function automatic req_t mk(input logic [4:0] cmd, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                              input logic [2:0] typ, input logic [DW-1:0] data, input logic [3:0] mask,
                              input logic kill);
    req_t r;
    r.cmd = cmd; r.addr = addr; r.tag = tag; r.typ = typ; r.data = data; r.mask = mask; r.kill = kill;
    return r;
  endfunction

  // One clock; compare the response bus against whatever is due this cycle (or all-zero).
  task automatic tick();
    exp_t        x;
    logic [63:0] e;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    e = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      x = exp_q.pop_front();
      e = x.rsp;
    end
    chk("rsp", pack_rsp(rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data), e);
  endtask

  // Reference: ops take effect in acceptance order; response appears L cycles after accept.
  task automatic model(input req_t r);
    int   idx;
    exp_t x;
    idx   = int'((r.addr >> 2) % WORDS);
    x.due = cyc + L;
    if (!r.kill) begin
      if (r.cmd == 5'd0) begin
        x.rsp = pack_rsp(1'b1, 1'b0, r.tag, r.typ, mm[idx]);
      end else if (r.cmd == 5'd1) begin
        for (int b = 0; b < 4; b++)
          if (r.mask[b]) mm[idx][8*b +: 8] = r.data[8*b +: 8];
        x.rsp = pack_rsp(1'b1, 1'b0, r.tag, r.typ, '0);
      end else begin
        x.rsp = pack_rsp(1'b0, 1'b1, r.tag, r.typ, '0);
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic cycle_drive(input logic vld, input req_t r, output logic acc);
    req_valid     = vld;
    req_addr      = r.addr;
    req_tag       = r.tag;
    req_cmd       = r.cmd;
    req_typ       = r.typ;
    req_data_mask = r.mask;
    req_data      = pend_data;
    req_kill      = pend_kill;
    #1;
    acc = vld && req_ready;
    if (vld && !req_ready) low_seen++;
    if (acc) model(r);
    pend_data = acc ? r.data : $urandom();
    pend_kill = acc ? r.kill : ($urandom_range(0, 3) == 0);
    tick();
  endtask

  task automatic send(input req_t r);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      cycle_drive(1'b1, r, acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    req_t z;
    logic a;
    z = mk('0, '0, '0, '0, '0, '0, 1'b0);
    repeat (n) cycle_drive(1'b0, z, a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   c;

    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("rst_ready", {63'd0, req_ready}, 64'd0);
    end
    reset = 1'b0;
    idle(1);
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // store then back-to-back load of same word
    send(mk(5'd1, 32'h10, 7'd3, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0));
    send(mk(5'd0, 32'h10, 7'd4, 3'd2, '0, '0, 1'b0));
    idle(4);

    // byte-masked merge
    send(mk(5'd1, 32'h40, 7'd5, 3'd1, 32'h11223344, 4'hF, 1'b0));
    send(mk(5'd1, 32'h40, 7'd6, 3'd1, 32'hAABBCCDD, 4'b0101, 1'b0));
    send(mk(5'd0, 32'h40, 7'd7, 3'd1, '0, '0, 1'b0));
    idle(4);

    // unsupported command, then confirm memory untouched
    send(mk(5'd7, 32'h10, 7'd9, 3'd3, 32'h01234567, 4'hF, 1'b0));
    send(mk(5'd0, 32'h10, 7'd10, 3'd3, '0, '0, 1'b0));
    idle(4);

    // killed store with a load accepted in the kill cycle, then address wrap
    send(mk(5'd1, 32'h20, 7'd11, 3'd0, 32'h55667788, 4'hF, 1'b0));
    idle(2);
    send(mk(5'd1, 32'h20, 7'd12, 3'd0, 32'h0BADF00D, 4'hF, 1'b1));
    send(mk(5'd0, 32'h20, 7'd13, 3'd0, '0, '0, 1'b0));
    send(mk(5'd0, 32'h20 + WORDS * 4, 7'd14, 3'd0, '0, '0, 1'b0));
    idle(4);

    // reset while a store sits in S1: no write, no response
    send(mk(5'd1, 32'h30, 7'd15, 3'd0, 32'h00001234, 4'hF, 1'b0));
    idle(3);
    mm_save = mm;
    send(mk(5'd1, 32'h30, 7'd16, 3'd0, 32'hFFFF0000, 4'hF, 1'b0));
    reset = 1'b1;
    exp_q.delete();
    mm = mm_save;
    idle(2);
    reset = 1'b0;
    idle(1);
    send(mk(5'd0, 32'h30, 7'd17, 3'd0, '0, '0, 1'b0));
    idle(4);

    // random traffic over 16 words, with aliased upper and byte-offset address bits
    for (int w = 0; w < 16; w++)
      send(mk(5'd1, 32'(w) << 2, 7'(w), 3'd0, $urandom(), 4'hF, 1'b0));
    for (int i = 0; i < 200; i++) begin
      c = $urandom_range(0, 9);
      r.cmd  = (c < 5) ? 5'd0 : (c < 9) ? 5'd1 : 5'($urandom_range(2, 31));
      r.addr = ($urandom() & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      r.tag  = 7'($urandom());
      r.typ  = 3'($urandom());
      r.data = $urandom();
      r.mask = 4'($urandom());
      r.kill = ($urandom_range(0, 9) == 0);
      send(r);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(L + 4);
    chk("drain", 64'(exp_q.size()), 64'd0);
`ifdef HELLA_CACHE_SLAVE_MEM_BACKPRESSURE_EN
    chk("ready_low_seen", {63'd0, low_seen > 0}, 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
